cdc_handshake_tx: RTL
=====================

CDC_HANDSHAKE_TX -- requirements
Module: cdc_handshake_tx

Interface
REQ-001 Parameter WIDTH SHALL default to 8; it is the payload width in bits.
REQ-002 Parameter TIMEOUT SHALL default to 255; it is the maximum number of cycles to wait for ack high, and 0 disables the timeout.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-004 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 in_valid  input  1  SHALL mean the local source offers in_data.
REQ-006 in_data  input  WIDTH  SHALL be the payload, sampled only on accept.
REQ-007 in_ready  output  1  SHALL mean the block can accept a payload this cycle.
REQ-008 req  output  1  SHALL be the level request toward the remote domain, driven directly from a flop.
REQ-009 tx_data  output  WIDTH  SHALL be the payload toward the remote domain, driven directly from flops.
REQ-010 ack  input  1  SHALL be the asynchronous level acknowledge from the remote domain.
REQ-011 done  output  1  SHALL be a one-cycle pulse marking a completed four-phase transfer.
REQ-012 err  output  1  SHALL be a one-cycle pulse marking a transfer aborted by timeout.

Function
REQ-013 ack SHALL pass through a 2-flop synchronizer to form ack_s, adding 2 cycles of latency; raw ack SHALL NOT reach any other logic.
REQ-014 The FSM SHALL have exactly three states: IDLE, REQ_HI and WAIT_LO.
REQ-015 in_ready SHALL equal (state==IDLE && ack_s==0), so a stale high ack blocks a new transfer.
REQ-016 Accept SHALL occur when in_valid && in_ready; on the next cycle, req=1, tx_data=in_data, and state=REQ_HI.
REQ-017 tx_data SHALL change only on accept and SHALL be held stable through REQ_HI and WAIT_LO.
REQ-018 In REQ_HI, ack_s==1 SHALL cause req=0 and state=WAIT_LO on the next cycle.
REQ-019 In WAIT_LO, ack_s==0 SHALL cause state=IDLE and done=1 for exactly one cycle.
REQ-020 The timeout counter SHALL clear on accept and increment once per cycle in REQ_HI.
REQ-021 If the timeout counter reaches TIMEOUT while ack_s==0 and TIMEOUT!=0, then on the next cycle req=0, state=WAIT_LO and err=1 for one cycle.
REQ-022 After a timeout, done SHALL NOT pulse for that transfer.
REQ-023 The timeout counter SHALL be $clog2(TIMEOUT+1) bits wide, with a minimum of 1 bit, and SHALL saturate rather than wrap.
REQ-024 If ack_s rises in the same cycle the counter reaches TIMEOUT, ack SHALL win: done, no err.
REQ-025 in_valid SHALL be ignored outside IDLE; there is no queuing, and at most one transfer is in flight.
REQ-026 done and err SHALL never be asserted in the same cycle.

Reset
REQ-027 While rst==0: state=IDLE, req=0, tx_data=0, done=0, err=0, counter=0, and both synchronizer flops=0, all asynchronously.
REQ-028 Reset asserted mid-transfer SHALL drop req immediately, with no done or err pulse.
REQ-029 After reset release, a transfer SHALL NOT be accepted until ack_s==0 has been sampled.

Structure
REQ-030 The FSM state encoding and the default WIDTH/TIMEOUT constants SHALL live in the shared package cdc_pkg.
REQ-031 The ack synchronizer SHALL be one sub-module instance, sync_2ff, using clk and rst, active-low async.
REQ-032 The implementation SHALL be 120-400 lines of RTL, with no latches and no combinational path from ack to any output.

Verification
REQ-033 Basic: in_data=0xA5 with in_valid=1 in IDLE; remote ack rises 3 cycles after req and falls 3 cycles after req falls -> tx_data=0xA5 stable, req high then low, one done pulse, in_ready=1 afterwards.
REQ-034 Back-to-back: 0x01 then 0x02 offered continuously -> second accept only after done; tx_data shows 0x01 then 0x02, with no overlap of req.
REQ-035 Timeout: TIMEOUT=4, ack never rises -> req drops 5 cycles after accept, err pulses once, done never pulses.
REQ-036 Ack held high after timeout for 10 cycles -> state stays WAIT_LO and in_ready=0 until ack_s falls, then in_ready=1.
REQ-037 Reset mid-REQ_HI: rst=0 for 1 cycle -> req=0 asynchronously, tx_data=0, and no done or err pulse.
REQ-038 Tie: ack_s rises in the same cycle the counter reaches TIMEOUT -> done path taken, err stays 0.

Source files
------------

// File: rtl/cdc_pkg.sv
// Shared constants and FSM encoding for the four-phase handshake transmitter.
package cdc_pkg;

    localparam int DEFAULT_WIDTH   = 8;
    localparam int DEFAULT_TIMEOUT = 255;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ_HI  = 2'd1,
        WAIT_LO = 2'd2
    } state_e;

    // A TIMEOUT of 0 still needs a one-bit counter.
    function automatic int cnt_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop level synchronizer for a single asynchronous input bit.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/cdc_handshake_tx.sv
// Source side of a four-phase req/ack handshake carrying one payload word,
// with an optional timeout on the ack-high phase.
module cdc_handshake_tx
    import cdc_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             req,
    output logic [WIDTH-1:0] tx_data,
    input  logic             ack,
    output logic             done,
    output logic             err
);

    localparam int            CW      = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

    state_e           state_q, state_d;
    logic             req_q, req_d;
    logic [WIDTH-1:0] tx_data_q, tx_data_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             aborted_q, aborted_d;
    logic             ack_s;
    logic             accept;
    logic             timeout_hit;

    sync_2ff u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d   (ack),
        .q   (ack_s)
    );

    // A still-high ack from the previous transfer holds off the next one.
    assign in_ready    = (state_q == IDLE) && !ack_s;
    assign accept      = in_valid && in_ready;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_MAX);

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        tx_data_d = tx_data_q;
        cnt_d     = cnt_q;
        aborted_d = aborted_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = REQ_HI;
                    req_d     = 1'b1;
                    tx_data_d = in_data;
                    cnt_d     = '0;
                    aborted_d = 1'b0;
                end
            end
            REQ_HI: begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CW'(1);
                end
                // ack is checked first so a simultaneous ack beats the timeout.
                if (ack_s) begin
                    state_d = WAIT_LO;
                    req_d   = 1'b0;
                end else if (timeout_hit) begin
                    state_d   = WAIT_LO;
                    req_d     = 1'b0;
                    err_d     = 1'b1;
                    aborted_d = 1'b1;
                end
            end
            WAIT_LO: begin
                if (!ack_s) begin
                    state_d = IDLE;
                    done_d  = !aborted_q;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            tx_data_q <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            tx_data_q <= tx_data_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
            aborted_q <= aborted_d;
        end
    end

    assign req     = req_q;
    assign tx_data = tx_data_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule
